// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Memory-stage initiator for the 16-bit mem_system load/store interface.
//   Accepts one load/store at a time, holds it toward memory until Done/err or
//   timeout, then emits a one-cycle registered response. Misaligned requests
//   are answered with an error without touching memory. Successful accesses
//   update saturating hit/miss counters.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
//   req_ready=1. req_ready is high only in IDLE. rsp_valid is a one-cycle
//   pulse. There is no backpressure on the response. Response fields hold
//   until the next response is loaded.
//
// Parameters
//   TIMEOUT  max BUSY cycles without Done/err before abort (2..255)
//   CNT_MAX  saturation value of hit_cnt/miss_cnt (16'hFFFF in normal use)
//
// Ports
//   clk, rst (async, active low)
//   req_valid/req_wr/req_addr/req_wdata/req_ready   pipeline request side
//   rsp_valid/rsp_rdata/rsp_hit/rsp_err/rsp_misalign pipeline response side
//   hit_cnt/miss_cnt                                statistics
//   halt -> createdump                              pass-through
//   Addr/DataIn/Rd/Wr                               memory request
//   DataOut/Done/Stall/CacheHit/err                 memory status
//   o_dbg_state                                     current FSM state
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_hit,
  output logic        rsp_err,
  output logic        rsp_misalign,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  input  logic        halt,
  output logic [15:0] Addr,
  output logic [15:0] DataIn,
  output logic        Rd,
  output logic        Wr,
  output logic        createdump,
  input  logic [15:0] DataOut,
  input  logic        Done,
  input  logic        Stall,
  input  logic        CacheHit,
  input  logic        err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter value in the last allowed BUSY cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [7:0]  r_tmo;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_hit;
  logic        r_rsp_err;
  logic        r_rsp_mis;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        w_tmo_hit;
  // Stall is informational: the request is held regardless of it.
  logic        w_unused_stall;

  assign w_unused_stall = Stall;
  assign w_tmo_hit      = (r_tmo == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next_state = req_addr[0] ? S_RESP : S_BUSY;
      end
      S_BUSY: begin
        if (err || Done || w_tmo_hit) w_next_state = S_RESP;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request hold, timeout counter, response fields and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tmo       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_mis   <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_addr[0]) begin
              r_rsp_rdata <= '0;
              r_rsp_hit   <= 1'b0;
              r_rsp_err   <= 1'b1;
              r_rsp_mis   <= 1'b1;
            end else begin
              r_addr  <= req_addr;
              r_wdata <= req_wdata;
              r_wr    <= req_wr;
              r_tmo   <= '0;
            end
          end
        end
        S_BUSY: begin
          // err outranks a coincident Done: the access is not counted.
          if (err || (!Done && w_tmo_hit)) begin
            r_rsp_rdata <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_mis   <= 1'b0;
          end else if (Done) begin
            r_rsp_rdata <= r_wr ? 16'h0000 : DataOut;
            r_rsp_hit   <= CacheHit;
            r_rsp_err   <= 1'b0;
            r_rsp_mis   <= 1'b0;
            if (CacheHit) begin
              if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
              if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign Rd           = (r_state == S_BUSY) & ~r_wr;
  assign Wr           = (r_state == S_BUSY) &  r_wr;
  assign Addr         = r_addr;
  assign DataIn       = r_wdata;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_hit      = r_rsp_hit;
  assign rsp_err      = r_rsp_err;
  assign rsp_misalign = r_rsp_mis;
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;
  assign createdump   = halt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl
//   Directed and randomized transactions against mem_req_ctrl. Each
//   transaction's response, latency and memory-strobe duration are derived
//   from the event timing chosen for it (Done/err cycle or timeout).
//   Counters use a small saturating reference model.
module tb_mem_req_ctrl;

  localparam int          TO  = 64;
  localparam logic [15:0] SAT = 16'd40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_hit;
  logic        rsp_err;
  logic        rsp_misalign;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic        halt = 1'b0;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut = '0;
  logic        Done = 1'b0;
  logic        Stall = 1'b0;
  logic        CacheHit = 1'b0;
  logic        err = 1'b0;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int m_hit    = 0;
  int m_miss   = 0;

  mem_req_ctrl #(.TIMEOUT(TO), .CNT_MAX(SAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
    .rsp_err(rsp_err), .rsp_misalign(rsp_misalign),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .halt(halt), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done),
    .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .o_dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < int'(SAT)) ? v + 1 : v;
  endfunction

  // Drives one request and follows it to the IDLE cycle after its response.
  // done_at/err_at: BUSY cycle (1-based) in which Done/err pulse, 0 = never.
  task automatic run_txn(input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int done_at,
                         input int err_at, input logic hit,
                         input logic [15:0] dout);
    int          lat;
    int          rw_cycles;
    logic [15:0] e_rdata;
    logic        e_hit, e_err, e_mis;
    if (addr[0]) begin
      lat = 1; e_rdata = '0; e_hit = 0; e_err = 1; e_mis = 1;
    end else if (err_at != 0 && (done_at == 0 || err_at <= done_at)) begin
      lat = err_at + 1; e_rdata = '0; e_hit = 0; e_err = 1; e_mis = 0;
    end else if (done_at != 0) begin
      lat = done_at + 1; e_rdata = wr ? 16'h0 : dout;
      e_hit = hit; e_err = 0; e_mis = 0;
      if (hit) m_hit = sat_inc(m_hit);
      else     m_miss = sat_inc(m_miss);
    end else begin
      lat = TO + 1; e_rdata = '0; e_hit = 0; e_err = 1; e_mis = 0;
    end

    chk("req_ready_before", 32'(req_ready), 1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    rw_cycles = 0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (Rd || Wr) rw_cycles++;
      if (c < lat) begin
        chk("busy_rsp_valid", 32'(rsp_valid), 0);
        chk("busy_req_ready", 32'(req_ready), 0);
        chk("busy_Addr", 32'(Addr), 32'(addr));
        chk("busy_DataIn", 32'(DataIn), 32'(wdata));
        chk("busy_Rd", 32'(Rd), 32'(!wr));
        chk("busy_Wr", 32'(Wr), 32'(wr));
        // Request side noise must not be accepted while busy.
        req_valid = 1'($urandom_range(0, 1));
        req_wr    = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        Done      = (c == done_at);
        err       = (c == err_at);
        Stall     = 1'($urandom_range(0, 1));
        CacheHit  = hit;
        DataOut   = dout;
      end else if (c == lat) begin
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
        chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_misalign", 32'(rsp_misalign), 32'(e_mis));
        chk("resp_req_ready", 32'(req_ready), 0);
        req_valid = 1'b0;
        Done      = 1'($urandom_range(0, 1));
        err       = 1'($urandom_range(0, 1));
        CacheHit  = 1'($urandom_range(0, 1));
        DataOut   = 16'($urandom);
      end else begin
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        chk("idle_req_ready", 32'(req_ready), 1);
        chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
        chk("hold_rsp_err", 32'(rsp_err), 32'(e_err));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        Done = 1'b0;
        err  = 1'b0;
      end
      halt = 1'($urandom_range(0, 1));
      #1;
      chk("createdump", 32'(createdump), 32'(halt));
    end
    chk("rdwr_cycles", 32'(rw_cycles), addr[0] ? 0 : 32'(lat - 1));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_Rd", 32'(Rd), 0);
    chk("rst_Wr", 32'(Wr), 0);
    chk("rst_Addr", 32'(Addr), 0);
    chk("rst_DataIn", 32'(DataIn), 0);
    chk("rst_rsp_fields", 32'({rsp_rdata, rsp_hit, rsp_err, rsp_misalign}), 0);
    chk("rst_counters", 32'({hit_cnt, miss_cnt}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(1'b0, 16'h0024, 16'h0000, 1, 0, 1'b1, 16'hBEEF);   // load hit
    run_txn(1'b1, 16'h1000, 16'h1234, 20, 0, 1'b0, 16'hAAAA);  // store miss
    run_txn(1'b0, 16'h0003, 16'h0000, 1, 0, 1'b1, 16'h5555);   // misaligned
    run_txn(1'b0, 16'h0040, 16'h0000, 0, 0, 1'b0, 16'h0000);   // timeout
    run_txn(1'b1, 16'h0042, 16'h9999, 1, 0, 1'b1, 16'h0000);   // accepted after timeout
    run_txn(1'b0, 16'h0050, 16'h0000, 3, 3, 1'b1, 16'h7777);   // err with Done
    run_txn(1'b0, 16'h0052, 16'h0000, 5, 2, 1'b0, 16'h7777);   // err before Done

    // Randomized cases
    for (int n = 0; n < 30; n++) begin
      logic        r_wr;
      logic [15:0] r_addr;
      int          r_done, r_err, mode;
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 5) == 0) r_addr[0] = 1'b1;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        r_done = 0; r_err = 0;
      end else if (mode == 1) begin
        r_err = $urandom_range(1, 20); r_done = $urandom_range(0, 20);
      end else begin
        r_done = $urandom_range(1, 20); r_err = 0;
      end
      run_txn(r_wr, r_addr, 16'($urandom), r_done, r_err,
              1'($urandom_range(0, 1)), 16'($urandom));
    end

    // Saturation of both counters
    for (int n = 0; n < int'(SAT) + 3; n++)
      run_txn(1'b0, 16'h0100, 16'h0, 1, 0, 1'b1, 16'($urandom));
    chk("hit_cnt_sat", 32'(hit_cnt), 32'(SAT));
    for (int n = 0; n < int'(SAT) + 3; n++)
      run_txn(1'b1, 16'h0200, 16'($urandom), 1, 0, 1'b0, 16'h0);
    chk("miss_cnt_sat", 32'(miss_cnt), 32'(SAT));

    // Reset asserted mid-BUSY
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0300;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_Rd", 32'(Rd), 1);
    rst = 1'b0;
    #1;
    m_hit = 0; m_miss = 0;
    chk("async_rst_Rd", 32'(Rd), 0);
    chk("async_rst_req_ready", 32'(req_ready), 1);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("async_rst_hit_cnt", 32'(hit_cnt), 32'(m_hit));
    chk("async_rst_miss_cnt", 32'(miss_cnt), 32'(m_miss));
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      Done = (c == 1);
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("post_rst_req_ready", 32'(req_ready), 1);
    end
    Done = 1'b0;
    run_txn(1'b0, 16'h0400, 16'h0, 2, 0, 1'b0, 16'hC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
